// File: rtl/mem_access_seq.sv
// mem_access_seq: burst memory-access sequencer running the READ/WRITE + MFC handshake per word with wait-state timeout
module mem_access_seq #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int LEN_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
    parameter int TIMEOUT   = 15,
    parameter int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              read,
    output logic              write,
    input  logic              MFC
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;
    localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    state_t state_q, state_d;
    logic ready_q, ready_d, dir_q, dir_d, read_q, read_d, write_q, write_d;
    logic pop_q, pop_d, rv_q, rv_d, done_q, done_d, err_q, err_d;
    logic [LEN_W:0] beats_q, beats_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic timeout;
    assign timeout = (TIMEOUT != 0) && (wait_q == TO_LAST);
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        read_d  = read_q;
        write_d = write_q;
        pop_d   = 1'b0;
        rv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        beats_d = beats_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                dir_d   = req_write;
                beats_d = ({1'b0, req_len} > MAX_LEN) ? MAX_LEN : {1'b0, req_len};
                addr_d  = req_addr;
                wdata_d = wr_data;
                read_d  = !req_write;
                write_d = req_write;
                wait_d  = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (MFC) begin
                rdata_d = dir_q ? rdata_q : mem_rdata;
                rv_d    = !dir_q;
                pop_d   = dir_q;
                read_d  = 1'b0;
                write_d = 1'b0;
                wait_d  = '0;
                state_d = RELEASE;
            end else if (timeout) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
            RELEASE: if (!MFC && beats_q != '0) begin
                addr_d  = addr_q + 1'b1;
                wdata_d = wr_data;
                read_d  = !dir_q;
                write_d = dir_q;
                beats_d = beats_q - 1'b1;
                wait_d  = '0;
                state_d = WAIT_ACK;
            end else if (!MFC || timeout) begin
                // MFC stuck high past the limit aborts just like a missing ack
                done_d  = 1'b1;
                err_d   = MFC;
                state_d = IDLE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            dir_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            pop_q   <= 1'b0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            beats_q <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            dir_q   <= dir_d;
            read_q  <= read_d;
            write_q <= write_d;
            pop_q   <= pop_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
            err_q   <= err_d;
            beats_q <= beats_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    assign req_ready = ready_q;
    assign read      = read_q;
    assign write     = write_q;
    assign wr_pop    = pop_q;
    assign rd_valid  = rv_q;
    assign done      = done_q;
    assign error     = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rd_data   = rdata_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed per-cycle vectors plus hand-written timeout, stuck-MFC and reset sequences
module tb_mem_access_seq;
    logic clock = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0, MFC = 1'b0;
    logic [15:0] req_addr = '0, wr_data = '0, mem_rdata = '0;
    logic [1:0] req_len = '0;
    logic req_ready, wr_pop, rd_valid, done, error, read, write;
    logic [15:0] rd_data, mem_addr, mem_wdata;
    int checks = 0, failures = 0;

    mem_access_seq dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
        .wr_pop(wr_pop), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .error(error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .read(read), .write(write), .MFC(MFC)
    );

    always #5 clock = ~clock;

    // flags order: ready read write pop rd_valid done error
    typedef struct {
        logic rv; logic rw; logic [15:0] addr; logic [1:0] len; logic [15:0] wd; logic [15:0] rdat; logic mfc;
        logic [6:0] f; logic [15:0] ea; logic [15:0] ew; logic [15:0] er;
    } vec_t;
    vec_t tv[$];

    function automatic logic [54:0] outs();
        return {req_ready, read, write, wr_pop, rd_valid, done, error, mem_addr, mem_wdata, rd_data};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic rv, input logic rw, input logic [15:0] a, input logic [1:0] l,
                       input logic [15:0] wd, input logic [15:0] rd, input logic m);
        req_valid = rv; req_write = rw; req_addr = a; req_len = l; wr_data = wd; mem_rdata = rd; MFC = m;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("reset_state", 64'(outs()), 64'({7'b1000000, 48'h0}));
        reset = 1'b0;
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b1000000,16'h0000,16'h0000,16'h0000});
        tv.push_back(vec_t'{1,0,16'h0040,0,16'h0000,16'h0000,0,7'b0100000,16'h0040,16'h0000,16'h0000});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b0100000,16'h0040,16'h0000,16'h0000});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'hBEEF,1,7'b0000100,16'h0040,16'h0000,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b1000010,16'h0040,16'h0000,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b1000000,16'h0040,16'h0000,16'hBEEF});
        tv.push_back(vec_t'{1,1,16'h0010,3,16'h1111,16'h0000,0,7'b0010000,16'h0010,16'h1111,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h1111,16'h0000,1,7'b0001000,16'h0010,16'h1111,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h2222,16'h0000,0,7'b0010000,16'h0011,16'h2222,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h2222,16'h0000,1,7'b0001000,16'h0011,16'h2222,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h3333,16'h0000,0,7'b0010000,16'h0012,16'h3333,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h3333,16'h0000,1,7'b0001000,16'h0012,16'h3333,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h4444,16'h0000,0,7'b0010000,16'h0013,16'h4444,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h4444,16'h0000,1,7'b0001000,16'h0013,16'h4444,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h5555,16'h0000,0,7'b1000010,16'h0013,16'h4444,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b1000000,16'h0013,16'h4444,16'hBEEF});
        tv.push_back(vec_t'{1,0,16'hFFFF,1,16'h0000,16'h0000,0,7'b0100000,16'hFFFF,16'h0000,16'hBEEF});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h00A1,1,7'b0000100,16'hFFFF,16'h0000,16'h00A1});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b0100000,16'h0000,16'h0000,16'h00A1});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h00A2,1,7'b0000100,16'h0000,16'h0000,16'h00A2});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b1000010,16'h0000,16'h0000,16'h00A2});
        tv.push_back(vec_t'{0,0,16'h0000,0,16'h0000,16'h0000,0,7'b1000000,16'h0000,16'h0000,16'h00A2});
        for (int i = 0; i < tv.size(); i++) begin
            drv(tv[i].rv, tv[i].rw, tv[i].addr, tv[i].len, tv[i].wd, tv[i].rdat, tv[i].mfc);
            tick();
            chk($sformatf("vec%0d", i), 64'(outs()), 64'({tv[i].f, tv[i].ea, tv[i].ew, tv[i].er}));
        end

        // timeout with MFC held low: read high 15 cycles, then abort
        drv(1, 0, 16'h0100, 0, 0, 0, 0);
        tick();
        n = int'(read);
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            tick();
            n += int'(read && !done);
        end
        chk("to_read_cycles", 64'(n), 64'd15);
        tick();
        chk("to_abort", 64'({req_ready, read, write, done, error}), 64'(5'b10011));
        tick();
        chk("to_done_pulse", 64'({req_ready, done, error}), 64'(3'b100));

        // MFC on the very timeout cycle wins
        drv(1, 0, 16'h0101, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) tick();
        chk("late_still_read", 64'({read, done}), 64'(2'b10));
        drv(0, 0, 0, 0, 0, 16'h5A5A, 1);
        tick();
        chk("late_ack", 64'({read, rd_valid, done, error, rd_data}), 64'({4'b0100, 16'h5A5A}));
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("late_done", 64'({req_ready, done, error}), 64'(3'b110));

        // stuck MFC after the first ack of a two-beat read
        drv(1, 0, 16'h0200, 1, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 16'h7777, 1);
        tick();
        chk("stuck_first_beat", 64'({rd_valid, rd_data}), 64'({1'b1, 16'h7777}));
        n = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            n += int'(read || rd_valid || done);
        end
        chk("stuck_no_strobe", 64'(n), 64'd0);
        tick();
        chk("stuck_abort", 64'({req_ready, read, done, error, mem_addr}), 64'({4'b1011, 16'h0200}));
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();

        // reset during the second beat of a four-beat read
        drv(1, 0, 16'h0300, 3, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 16'h0001, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_second_beat", 64'({read, mem_addr}), 64'({1'b1, 16'h0301}));
        reset = 1'b1;
        tick();
        chk("rst_outputs", 64'(outs()), 64'({7'b1000000, 48'h0}));
        reset = 1'b0;
        tick();
        chk("rst_no_done", 64'(outs()), 64'({7'b1000000, 48'h0}));

        // fresh request after reset, then a request held across the done cycle
        drv(1, 1, 16'h0400, 0, 16'hCAFE, 0, 0);
        tick();
        chk("post_rst_launch", 64'({write, mem_addr, mem_wdata}), 64'({1'b1, 16'h0400, 16'hCAFE}));
        drv(0, 0, 0, 0, 16'hCAFE, 0, 1);
        tick();
        chk("post_rst_pop", 64'({write, wr_pop}), 64'(2'b01));
        drv(1, 0, 16'h0500, 0, 0, 0, 0);
        tick();
        chk("post_rst_done", 64'({req_ready, read, done, error, mem_addr}), 64'({4'b1010, 16'h0400}));
        tick();
        chk("accept_after_done", 64'({req_ready, read, done, mem_addr}), 64'({3'b010, 16'h0500}));
        drv(0, 0, 0, 0, 0, 16'h1234, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("final_done", 64'({done, error, rd_data}), 64'({2'b10, 16'h1234}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clock) begin
        if (read && write) begin
            failures++;
            $display("FAIL strobe_exclusive read=%b write=%b", read, write);
        end
    end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised memory-access sequencer that sits between the CPU controller FSM and the memory bus.
- It takes single or burst read/write requests and runs the READ/WRITE + MFC handshake per word.
- It auto-increments the address and returns read data beat by beat.
- It adds a wait-state timeout with error reporting, so the controller no longer busy-waits on MFC in its own states.

Parameters:
DATA_W, 16, data bus width in bits
ADDR_W, 16, address bus width in bits
MAX_BURST, 4, maximum words per request (>=1)
LEN_W, $clog2(MAX_BURST) (min 1), width of req_len
TIMEOUT, 15, max cycles waited on an MFC edge before abort; 0 disables timeout
CNT_W, $clog2(TIMEOUT+1) (min 1), width of wait counter

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when req_valid&&req_ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  ADDR_W  first word address
req_len  in  LEN_W  beats minus one (0 = single word); values >= MAX_BURST clamp to MAX_BURST-1
wr_data  in  DATA_W  current write beat data, sampled at beat launch
wr_pop  out  1  1-cycle pulse: write beat completed, source advances wr_data
rd_valid  out  1  1-cycle pulse: rd_data holds a completed read beat
rd_data  out  DATA_W  captured read word
done  out  1  1-cycle pulse: request finished (normal or aborted)
error  out  1  valid with done; 1 = aborted by timeout
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_rdata  in  DATA_W  read data from memory, valid when MFC=1
read  out  1  memory read strobe
write  out  1  memory write strobe
MFC  in  1  memory function complete

Behaviour:
- All outputs are registered. On reset: state=IDLE, and req_ready=1, read=write=0, wr_pop=rd_valid=done=error=0, mem_addr=0, mem_wdata=0, rd_data=0, counters=0.
- Reset has priority over everything, including mid-burst; it aborts with no done pulse.
- States:
  - IDLE, WAIT_ACK, RELEASE.
  - req_ready=1 only in IDLE.
- IDLE: on accept, latch req_write and the clamped beat count, and set mem_addr=req_addr, mem_wdata=wr_data. Assert read (or write) and clear wait_cnt -> WAIT_ACK. The strobe is visible the cycle after accept.
- WAIT_ACK, MFC=1 sampled:
  - read: rd_data<=mem_rdata, rd_valid pulse.
  - write: wr_pop pulse.
  - Drop the strobe, clear wait_cnt -> RELEASE.
- WAIT_ACK, MFC=0: wait_cnt++. If TIMEOUT!=0 and wait_cnt==TIMEOUT-1: drop the strobe, done=1, error=1 -> IDLE.
- RELEASE, MFC=0 sampled:
  - If beats remain: mem_addr<=mem_addr+1 (wraps modulo 2^ADDR_W), mem_wdata<=wr_data, reassert the strobe, decrement beats, clear wait_cnt -> WAIT_ACK.
  - If no beats remain: done=1, error=0 -> IDLE.
- RELEASE, MFC=1: wait_cnt++, with the same timeout abort as WAIT_ACK (stuck MFC). No strobe is asserted while waiting.
- Simultaneous events:
  - MFC arriving on the timeout cycle counts as success, not error.
  - req_valid during done is ignored; it is accepted the next cycle (req_ready rises with the return to IDLE).
- Per-beat minimum latency is 2 cycles (strobe cycle + release cycle). A single-word request with immediate MFC gives done 3 cycles after accept.
- read and write are never both 1. The strobe is never reasserted before MFC has been seen low.
- Beat counter width is LEN_W+1; no underflow is possible.

Test Plan:
- Single read: req_addr=0x0040, len=0. MFC rises 2 cycles after read and drops 1 cycle later, with mem_rdata=0xBEEF. Expect: read high until MFC, one rd_valid with rd_data=0xBEEF, done=1, error=0, mem_addr=0x0040.
- Burst write: len=3, addr=0x0010, wr_data advanced on each wr_pop (0x1111, 0x2222, 0x3333, 0x4444), memory model acks each strobe. Expect mem_addr 0x10..0x13 paired with those data, 4 wr_pop pulses, one done.
- Address wrap: read, addr=0xFFFF, len=1. Expect second beat at mem_addr=0x0000.
- Timeout: TIMEOUT=15, MFC held 0. Expect read high for 15 cycles, then read=0, done=1, error=1, req_ready=1. Repeat with MFC arriving exactly on cycle 15: expect success, error=0.
- Stuck MFC: MFC held 1 after the first ack of a len=1 read. Expect one rd_valid, no second strobe, then timeout done+error.
- Reset mid-burst: assert reset during the second beat of len=3. Expect all outputs 0 and req_ready=1 the next cycle, no done. A new request after that completes normally.
